neuron_integrator: RTL and testbench

NEURON_INTEGRATOR -- requirements
Module: neuron_integrator

---
 rtl/neuron_integrator.sv | 101 ++++++++++
 tb/tb_neuron_integrator.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_integrator.sv
// Time-multiplexed leaky integrate-and-fire membrane integrator with a one-deep result register.
// Optional MEMBRANE_SATURATE_EN clamps the membrane sum instead of wrapping it.
module neuron_integrator #(
  parameter int unsigned N_STAGE   = 6,
  parameter int unsigned N_NEURONS = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  input  logic [2:0]              shift,
  input  logic [N_STAGE:0]        threshold,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N_STAGE+1:0]      in_current,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_spike,
  output logic [N_STAGE+1:0]      out_u,
  output logic [((N_NEURONS > 1) ? $clog2(N_NEURONS) : 1)-1:0] out_index,
  output logic                    out_last
);

  localparam int unsigned W  = N_STAGE + 2;
  localparam int unsigned TW = N_STAGE + 1;
  localparam int unsigned IW = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;

  logic signed [W-1:0] mem_q [N_NEURONS];
  logic [IW-1:0]       idx_q;

  logic                accept;
  logic                idx_last;
  logic signed [W-1:0] u_cur;
  logic signed [W-1:0] decay;
  logic signed [W-1:0] d;
  logic signed [W-1:0] cur;
  logic signed [W:0]   s_wide;
  logic signed [W-1:0] s;
  logic signed [W:0]   s_ext;
  logic signed [W:0]   thr_ext;
  logic                spike;
  logic signed [W-1:0] u_new;

  // Only one result may be outstanding; a consumed result frees the slot in the same cycle.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign idx_last = (idx_q == IW'(N_NEURONS - 1));

  // Decay, integrate, fire and reset-by-subtraction for the neuron at idx_q.
  always_comb begin
    u_cur   = mem_q[idx_q];
    decay   = u_cur >>> shift;
    d       = (shift == 3'd0) ? u_cur : u_cur - decay;
    cur     = $signed(in_current);
    s_wide  = {d[W-1], d} + {cur[W-1], cur};
`ifdef MEMBRANE_SATURATE_EN
    if (s_wide[W] != s_wide[W-1]) begin
      s = s_wide[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end else begin
      s = s_wide[W-1:0];
    end
`else
    s = s_wide[W-1:0];
`endif
    s_ext   = {s[W-1], s};
    thr_ext = {2'b00, threshold};
    spike   = !s[W-1] && (s_ext >= thr_ext);
    // s >= threshold >= 0 when spiking, so the subtraction cannot leave the W-bit range
    u_new   = spike ? (s - $signed({1'b0, threshold})) : s;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(N_NEURONS); i++) mem_q[i] <= '0;
      idx_q     <= '0;
      out_valid <= 1'b0;
      out_spike <= 1'b0;
      out_u     <= '0;
      out_index <= '0;
      out_last  <= 1'b0;
    end else if (clear) begin
      // A simultaneous accept is dropped: clear wins.
      for (int i = 0; i < int'(N_NEURONS); i++) mem_q[i] <= '0;
      idx_q     <= '0;
      out_valid <= 1'b0;
    end else if (accept) begin
      mem_q[idx_q] <= u_new;
      out_u        <= u_new;
      out_spike    <= spike;
      out_index    <= idx_q;
      out_last     <= idx_last;
      out_valid    <= 1'b1;
      idx_q        <= idx_last ? '0 : idx_q + IW'(1);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  logic unused_tw;
  assign unused_tw = (TW == 0);

endmodule

// File: tb/tb_neuron_integrator.sv
// Self-checking bench for neuron_integrator: directed vector table, hand sequences, random vs model.
module tb_neuron_integrator;

  localparam int N_STAGE = 6;
  localparam int W       = N_STAGE + 2;
  localparam int TW      = N_STAGE + 1;
  localparam int N       = 8;
  localparam int IW      = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          clear;
  logic [2:0]    shift;
  logic [TW-1:0] threshold;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_current;
  logic          out_valid;
  logic          out_ready;
  logic          out_spike;
  logic [W-1:0]  out_u;
  logic [IW-1:0] out_index;
  logic          out_last;

  neuron_integrator #(.N_STAGE(N_STAGE), .N_NEURONS(N)) dut (
    .clk(clk), .reset(reset), .clear(clear), .shift(shift), .threshold(threshold),
    .in_valid(in_valid), .in_ready(in_ready), .in_current(in_current),
    .out_valid(out_valid), .out_ready(out_ready), .out_spike(out_spike),
    .out_u(out_u), .out_index(out_index), .out_last(out_last)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int su();
    return int'($signed(out_u));
  endfunction

  // ---------------- behavioural model ----------------
  int mem[N];
  int m_idx;
  bit m_valid;
  int m_spk, m_u, m_index, m_last;

  function automatic int fit(input int x);
    int lo = -(2 ** (W - 1));
    int hi = (2 ** (W - 1)) - 1;
    int span = 2 ** W;
    int r;
`ifdef MEMBRANE_SATURATE_EN
    if (x < lo) return lo;
    if (x > hi) return hi;
    return x;
`else
    r = ((x % span) + span) % span;
    if (r > hi) r -= span;
    return r;
`endif
  endfunction

  function automatic int floor_div(input int a, input int p);
    int q = a / p;
    if ((a % p != 0) && (a < 0)) q -= 1;
    return q;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < N; i++) mem[i] = 0;
    m_idx   = 0;
    m_valid = 0;
  endtask

  task automatic model_accept(input int sh, input int thr, input int cur);
    int u = mem[m_idx];
    int d = (sh == 0) ? u : u - floor_div(u, 2 ** sh);
    int s = fit(d + cur);
    int spk = (s >= 0 && s >= thr) ? 1 : 0;
    int un = spk ? s - thr : s;
    mem[m_idx] = un;
    m_spk   = spk;
    m_u     = un;
    m_index = m_idx;
    m_last  = (m_idx == N - 1) ? 1 : 0;
    m_valid = 1;
    m_idx   = (m_idx + 1) % N;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".valid"}, int'(out_valid), int'(m_valid));
    if (m_valid) begin
      check({tag, ".spike"}, int'(out_spike), m_spk);
      check({tag, ".u"}, su(), m_u);
      check({tag, ".index"}, int'(out_index), m_index);
      check({tag, ".last"}, int'(out_last), m_last);
    end
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    int sh;
    int thr;
    int cur;
    int spk;
    int u;
  } vec_t;

  vec_t tbl[24];

  task automatic set_vec(input int i, input int sh, input int thr, input int cur,
                         input int spk, input int u);
    tbl[i].sh = sh; tbl[i].thr = thr; tbl[i].cur = cur; tbl[i].spk = spk; tbl[i].u = u;
  endtask

  task automatic drive(input int sh, input int thr, input int cur);
    shift      = 3'(sh);
    threshold  = TW'(thr);
    in_current = W'(cur);
  endtask

  initial begin
    // timestep 1 from zeroed membranes
    set_vec(0, 0, 127, 64, 0, 64);
    set_vec(1, 0, 127, -64, 0, -64);
    set_vec(2, 0, 127, 120, 0, 120);
    set_vec(3, 0, 100, 40, 0, 40);
    for (int i = 4; i < 8; i++) set_vec(i, 0, 127, 0, 0, 0);
    // timestep 2: decay by half, overflow on neuron 2
    set_vec(8, 1, 127, 0, 0, 32);
    set_vec(9, 1, 127, 0, 0, -32);
`ifdef MEMBRANE_SATURATE_EN
    set_vec(10, 0, 127, 100, 1, 0);
`else
    set_vec(10, 0, 127, 100, 0, -36);
`endif
    set_vec(11, 0, 100, 40, 0, 80);
    for (int i = 12; i < 16; i++) set_vec(i, 7, 127, -1, 0, -1);
    // timestep 3: threshold-zero spike at s=0, negative overflow, s == threshold
    set_vec(16, 0, 0, -32, 1, 0);
`ifdef MEMBRANE_SATURATE_EN
    set_vec(17, 7, 127, -100, 0, -128);
    set_vec(18, 2, 100, 127, 1, 27);
`else
    set_vec(17, 7, 127, -100, 0, 125);
    set_vec(18, 2, 100, 127, 1, 0);
`endif
    set_vec(19, 0, 100, 40, 1, 20);
    for (int i = 20; i < 24; i++) set_vec(i, 0, 5, 6, 1, 0);

    reset = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    drive(0, 0, 0);
    #12;
    check("rst.valid", int'(out_valid), 0);
    check("rst.u", su(), 0);
    check("rst.index", int'(out_index), 0);
    check("rst.spike", int'(out_spike), 0);
    check("rst.last", int'(out_last), 0);
    reset = 1'b0;
    #1;
    check("rst.in_ready", int'(in_ready), 1);

    // table vectors, streamed back to back
    for (int i = 0; i < 24; i++) begin
      drive(tbl[i].sh, tbl[i].thr, tbl[i].cur);
      in_valid = 1'b1;
      tick();
      check($sformatf("tbl%0d.valid", i), int'(out_valid), 1);
      check($sformatf("tbl%0d.index", i), int'(out_index), i % N);
      check($sformatf("tbl%0d.last", i), int'(out_last), (i % N == N - 1) ? 1 : 0);
      check($sformatf("tbl%0d.spike", i), int'(out_spike), tbl[i].spk);
      check($sformatf("tbl%0d.u", i), su(), tbl[i].u);
    end

    // constant-current stream after clear: 40, 80, then spike leaving 20
    in_valid = 1'b0; clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clr.valid", int'(out_valid), 0);
    for (int i = 0; i < 24; i++) begin
      drive(0, 100, 40);
      in_valid = 1'b1;
      tick();
      check($sformatf("str%0d.index", i), int'(out_index), i % N);
      check($sformatf("str%0d.last", i), int'(out_last), (i % N == N - 1) ? 1 : 0);
      check($sformatf("str%0d.spike", i), int'(out_spike), (i / N == 2) ? 1 : 0);
      check($sformatf("str%0d.u", i), su(), (i / N == 0) ? 40 : (i / N == 1) ? 80 : 20);
    end

    // backpressure: pending result holds, nothing accepted
    out_ready = 1'b0;
    drive(0, 100, 10);
    in_valid = 1'b1;
    #1;
    check("bp.in_ready0", int'(in_ready), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("bp%0d.valid", i), int'(out_valid), 1);
      check($sformatf("bp%0d.index", i), int'(out_index), 7);
      check($sformatf("bp%0d.u", i), su(), 20);
      check($sformatf("bp%0d.spike", i), int'(out_spike), 1);
      check($sformatf("bp%0d.in_ready", i), int'(in_ready), 0);
    end
    out_ready = 1'b1;
    #1;
    check("bp.in_ready1", int'(in_ready), 1);
    tick();
    check("bp.next.index", int'(out_index), 0);
    check("bp.next.u", su(), 30);
    check("bp.next.spike", int'(out_spike), 0);

    // clear colliding with an accept at index 5
    for (int i = 1; i < 5; i++) begin
      drive(0, 100, 0);
      tick();
    end
    check("pre5.index", int'(out_index), 4);
    clear = 1'b1;
    drive(0, 100, 33);
    tick();
    clear = 1'b0;
    check("clr5.valid", int'(out_valid), 0);
    in_valid = 1'b0;
    tick();
    check("clr5.idle", int'(out_valid), 0);
    drive(0, 100, 7);
    in_valid = 1'b1;
    tick();
    check("clr5.next.index", int'(out_index), 0);
    check("clr5.next.u", su(), 7);

    // asynchronous reset between edges
    for (int i = 0; i < 3; i++) begin
      drive(0, 100, 7);
      tick();
    end
    check("prerst.index", int'(out_index), 3);
    #3;
    reset = 1'b1;
    #1;
    check("arst.valid", int'(out_valid), 0);
    check("arst.u", su(), 0);
    check("arst.index", int'(out_index), 0);
    check("arst.last", int'(out_last), 0);
    #2;
    reset = 1'b0;
    drive(0, 100, 55);
    #1;
    check("arst.in_ready", int'(in_ready), 1);
    tick();
    check("arst.next.valid", int'(out_valid), 1);
    check("arst.next.index", int'(out_index), 0);
    check("arst.next.u", su(), 55);

    // random traffic against the model
    in_valid = 1'b0; clear = 1'b1;
    tick();
    clear = 1'b0;
    model_clear();
    for (int n = 0; n < 600; n++) begin
      int sh  = int'($urandom_range(7));
      int thr = int'($urandom_range(127));
      int cur = int'($urandom_range(255)) - 112;
      bit rdy;
      drive(sh, thr, cur);
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      clear     = ($urandom % 40) == 0;
      #1;
      rdy = !m_valid || out_ready;
      check($sformatf("rnd%0d.in_ready", n), int'(in_ready), int'(rdy));
      if (clear) model_clear();
      else if (in_valid && rdy) model_accept(sh, thr, cur);
      else if (out_ready) m_valid = 0;
      tick();
      check_model($sformatf("rnd%0d", n));
    end
    clear = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
